tl_arbiter_a: RTL
=================

Name: tl_arbiter_A

Overview:
- Per-slave TileLink A-channel arbiter. It shares one slave port between MASTER_NUM requesters.
- It sits downstream of the per-master A-channel address routers in tl_xbar. Input i carries router valid bit i for this slave.
- Selection is round-robin. The grant is locked for the full length of multi-beat data bursts.
- It exports the winning master index so the D-channel return path can route responses.

Parameters:
- MASTER_NUM, 4, number of requesting masters (2 or more).
- BEAT_BYTES, 8, data bytes per beat; power of two.
- SIZE_WIDTH, 3, width of the a_size field (log2 of transfer bytes).
- DATA_T, logic[0:0], packed A-channel payload type, passed through untouched.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-low.
- req_valid_i  in  MASTER_NUM  per-master A valid.
- req_ready_o  out  MASTER_NUM  per-master A ready.
- req_data_i  in  MASTER_NUM x DATA_T  per-master payload.
- req_opcode_i  in  MASTER_NUM x 3  per-master a_opcode.
- req_size_i  in  MASTER_NUM x SIZE_WIDTH  per-master a_size.
- oup_valid_o  out  1  slave A valid.
- oup_ready_i  in  1  slave A ready.
- oup_data_o  out  DATA_T  muxed payload of the granted master.
- grant_idx_o  out  IDX_W  index of the granted master; IDX_W = max(1, clog2(MASTER_NUM)).
- busy_o  out  1  high while in BURST.

Behaviour:
- Reset values:
  - state = IDLE, rr_ptr = 0, owner = 0, beat_cnt = 0.
  - oup_valid_o = 0, req_ready_o = 0, busy_o = 0, grant_idx_o = 0.
- Data-carrying opcodes: PutFullData 0, PutPartialData 1, ArithmeticData 2, LogicalData 3.
- Beat count: beats = 1 unless the opcode is data-carrying and size > LOG_BB (LOG_BB = log2(BEAT_BYTES)). In that case beats = 1 << (size - LOG_BB).
- Counter width: CNT_W = max(1, 2^SIZE_WIDTH - LOG_BB) bits.
- IDLE:
  - Combinational round-robin pick: first i with req_valid_i[i] set, searching from rr_ptr upward with wrap to 0.
  - grant_idx_o = winner; oup_valid_o = any req_valid_i.
  - oup_data_o = req_data_i[winner]; req_ready_o[winner] = oup_ready_i; all other ready bits are 0.
  - Latency is zero: a fully combinational path from master to slave, with no storage of payload.
  - If no request is valid: grant_idx_o = rr_ptr, oup_valid_o = 0.
- Handshake in IDLE (oup_valid_o & oup_ready_i):
  - beats == 1: stay IDLE; rr_ptr <= (winner + 1) mod MASTER_NUM.
  - beats > 1: go to BURST; owner <= winner; beat_cnt <= beats - 1.
- BURST:
  - Only the owner is passed through: grant_idx_o = owner, oup_valid_o = req_valid_i[owner].
  - req_ready_o[owner] = oup_ready_i; all other ready bits are 0, even if those masters are valid.
  - opcode and size are ignored on non-first beats.
  - Each handshake decrements beat_cnt.
  - On the handshake with beat_cnt == 1: go to IDLE; rr_ptr <= (owner + 1) mod MASTER_NUM.
- Owner valid dropping mid-burst: the lock is held. oup_valid_o goes low and no other master is granted.
- Fairness: a master waiting with valid high is granted within MASTER_NUM - 1 completed messages.
- A grant change occurs only at message boundaries. The winner must not change while oup_valid_o is high and unaccepted (IDLE stall).
  - Holding the pick needs a registered "pending" flag plus a held index.
  - pend sets on oup_valid_o & ~oup_ready_i in IDLE and clears on the handshake.
  - While pend is set, the held index is used instead of the round-robin pick.
- MASTER_NUM not a power of two: the pointer wraps at MASTER_NUM-1 -> 0.
- Reset asserted mid-burst: returns asynchronously to the reset values. A partially passed burst is abandoned; upstream is reset alongside it.
- Simultaneous last-beat handshake and new requests: the new pick is evaluated in the next cycle from the updated rr_ptr.

Decomposition:
- Into tl_pkg:
  - the opcode enum (tl_a_opcode_e, values 0..7);
  - a function tl_has_data(opcode);
  - a function tl_num_beats(opcode, size, LOG_BB).
- State enum {IDLE, BURST} stays local.
- One sub-module: tl_rr_picker, a parameterised round-robin priority encoder (req vector + pointer -> one-hot and index, any_valid). It is reusable for the D-channel arbiter.

Test Plan:
- Round-robin sequence: MASTER_NUM=4, BEAT_BYTES=8; all four masters issue Get size 3, oup_ready_i = 1 → grant_idx_o sequence 0,1,2,3,0; one handshake per cycle.
- Burst lock: master 1 PutFullData size 5 (4 beats) while master 2 is valid → four consecutive beats from master 1; master 2 ready stays 0; then master 2 is granted; busy_o is high for 3 cycles.
- Burst bubble and backpressure: owner valid drops in beat 2 for 3 cycles and oup_ready_i toggles → no other grant; beat order preserved; exactly 4 handshakes.
- Pending stall: master 0 valid, oup_ready_i = 0 for 5 cycles, master 3 asserts in cycle 2 → grant stays 0 and payload is stable until the handshake.
- Single-beat cases: Get size 6 (no data) → 1 beat; PutFullData size 2 → 1 beat; no BURST entry.
- Reset mid-burst: rst_i low during beat 2 of 8 → outputs reset immediately; after release master 3's request is granted with rr_ptr = 0.

Source files
------------

// File: rtl/tl_arbiter_a_pkg.sv
// TileLink A-channel helpers shared by the arbiter, its round-robin picker and
// any future channel arbiters: opcode encoding and beat-count arithmetic.
package tl_arbiter_a_pkg;

    localparam int unsigned TL_OPCODE_W = 3;

    typedef enum logic [TL_OPCODE_W-1:0] {
        PUT_FULL_DATA    = 3'd0,
        PUT_PARTIAL_DATA = 3'd1,
        ARITHMETIC_DATA  = 3'd2,
        LOGICAL_DATA     = 3'd3,
        GET              = 3'd4,
        INTENT           = 3'd5,
        ACQUIRE_BLOCK    = 3'd6,
        ACQUIRE_PERM     = 3'd7
    } tl_a_opcode_e;

    // Opcodes whose message carries a data payload on the A channel.
    function automatic logic tl_has_data(input logic [TL_OPCODE_W-1:0] opcode);
        return opcode inside {PUT_FULL_DATA, PUT_PARTIAL_DATA, ARITHMETIC_DATA, LOGICAL_DATA};
    endfunction

    // Number of A-channel beats a message occupies; only data-carrying
    // messages larger than one beat span more than one cycle.
    function automatic int unsigned tl_num_beats(input logic [TL_OPCODE_W-1:0] opcode,
                                                 input int unsigned size,
                                                 input int unsigned log_bb);
        if (tl_has_data(opcode) && (size > log_bb)) begin
            return 32'd1 << (size - log_bb);
        end
        return 32'd1;
    endfunction

endpackage

// File: rtl/tl_arbiter_a_if.sv
// Bundle of the per-master request ports and the shared slave-side port of the
// A-channel arbiter. The master modport is the requester/slave environment,
// the slave modport is the arbiter itself.
interface tl_arbiter_a_if
    import tl_arbiter_a_pkg::*;
#(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned SIZE_WIDTH = 3,
    parameter type         DATA_T     = logic [0:0]
);
    localparam int unsigned IDX_W = (MASTER_NUM > 2) ? $clog2(MASTER_NUM) : 1;

    logic [MASTER_NUM-1:0]                  req_valid_i;
    logic [MASTER_NUM-1:0]                  req_ready_o;
    DATA_T [MASTER_NUM-1:0]                 req_data_i;
    logic [MASTER_NUM-1:0][TL_OPCODE_W-1:0] req_opcode_i;
    logic [MASTER_NUM-1:0][SIZE_WIDTH-1:0]  req_size_i;
    logic                                   oup_valid_o;
    logic                                   oup_ready_i;
    DATA_T                                  oup_data_o;
    logic [IDX_W-1:0]                       grant_idx_o;
    logic                                   busy_o;

    modport master (
        output req_valid_i, req_data_i, req_opcode_i, req_size_i, oup_ready_i,
        input  req_ready_o, oup_valid_o, oup_data_o, grant_idx_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_data_i, req_opcode_i, req_size_i, oup_ready_i,
        output req_ready_o, oup_valid_o, oup_data_o, grant_idx_o, busy_o
    );

endinterface

// File: rtl/tl_arbiter_a_rr_picker.sv
// Round-robin priority encoder: returns the first set request at or above ptr,
// wrapping past N-1 to 0. Works for any N >= 2, power of two or not.
module tl_rr_picker #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 2) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    assign any = |req;

    // Scan offsets from farthest to nearest so the nearest valid request wins.
    always_comb begin
        int c;
        c      = 0;
        onehot = '0;
        idx    = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= int'(N)) begin
                c = c - int'(N);
            end
            if (req[c[IDX_W-1:0]]) begin
                onehot                 = '0;
                onehot[c[IDX_W-1:0]]   = 1'b1;
                idx                    = c[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tl_arbiter_a.sv
// Per-slave TileLink A-channel arbiter: round-robin between masters with the
// grant locked for the whole of a multi-beat burst, and the pick held while a
// presented first beat is being back-pressured.
//
// state | meaning
// IDLE  | message boundary; round-robin pick (or held pick while stalled)
// BURST | remaining beats of a multi-beat message from owner only
module tl_arbiter_a
    import tl_arbiter_a_pkg::*;
#(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned BEAT_BYTES = 8,
    parameter int unsigned SIZE_WIDTH = 3,
    parameter type         DATA_T     = logic [0:0]
) (
    input  logic          clk_i,
    input  logic          rst_i,
    tl_arbiter_a_if.slave bus
);

    localparam int unsigned LOG_BB  = $clog2(BEAT_BYTES);
    localparam int unsigned IDX_W   = (MASTER_NUM > 2) ? $clog2(MASTER_NUM) : 1;
    localparam int          CNT_RAW = (2 ** SIZE_WIDTH) - int'(LOG_BB);
    localparam int unsigned CNT_W   = (CNT_RAW > 1) ? CNT_RAW : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e                state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      owner;
    logic [IDX_W-1:0]      held_idx;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  pend;
    logic                  busy_q;

    logic [MASTER_NUM-1:0] pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [IDX_W-1:0]      grant;
    logic                  oup_valid;
    logic                  hs;
    logic [MASTER_NUM-1:0] ready_vec;
    int unsigned           first_beats;
    logic                  multi;
    logic [CNT_W-1:0]      first_cnt;
    DATA_T                 data_mux;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(MASTER_NUM - 1)) ? '0 : i + 1'b1;
    endfunction

    tl_rr_picker #(
        .N     (MASTER_NUM),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (bus.req_valid_i),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Grant source: burst owner, else held stalled pick, else fresh round-robin pick.
    always_comb begin
        grant     = rr_ptr;
        oup_valid = 1'b0;
        if (state == BURST) begin
            grant     = owner;
            oup_valid = bus.req_valid_i[owner];
        end else if (pend) begin
            grant     = held_idx;
            oup_valid = bus.req_valid_i[held_idx];
        end else if (pick_any) begin
            grant     = pick_idx;
            oup_valid = 1'b1;
        end
    end

    // Ready goes back only to the granted master, and only when it can complete.
    always_comb begin
        ready_vec = '0;
        if ((state == IDLE) && !pend) begin
            ready_vec = pick_onehot;
        end else begin
            ready_vec[grant] = 1'b1;
        end
        if (!hs) begin
            ready_vec = '0;
        end
    end

    // First-beat decode of the granted message; ignored once inside a burst.
    always_comb begin
        first_beats = tl_num_beats(bus.req_opcode_i[grant], 32'(bus.req_size_i[grant]), LOG_BB);
        multi       = first_beats > 32'd1;
        first_cnt   = CNT_W'(first_beats - 32'd1);
        data_mux    = bus.req_data_i[grant];
    end

    assign hs              = oup_valid & bus.oup_ready_i;
    assign bus.oup_valid_o = oup_valid;
    assign bus.oup_data_o  = data_mux;
    assign bus.grant_idx_o = grant;
    assign bus.req_ready_o = ready_vec;
    assign bus.busy_o      = busy_q;

    // Arbitration FSM: message boundaries advance rr_ptr, bursts lock the owner.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            held_idx <= '0;
            beat_cnt <= '0;
            pend     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Re-evaluated every cycle so a withdrawn request cannot wedge the pick.
                    pend     <= oup_valid & ~bus.oup_ready_i;
                    held_idx <= grant;
                    if (hs) begin
                        if (multi) begin
                            state    <= BURST;
                            owner    <= grant;
                            beat_cnt <= first_cnt;
                            busy_q   <= 1'b1;
                        end else begin
                            rr_ptr <= wrap_inc(grant);
                        end
                    end
                end
                BURST: begin
                    if (hs) begin
                        beat_cnt <= beat_cnt - 1'b1;
                        if (beat_cnt == CNT_W'(1)) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            rr_ptr <= wrap_inc(owner);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
